// File: rtl/serial_addsub_if.sv
// Handshake bundle for serial_addsub: an operand channel in and a result channel out.
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer/consumer side: issues operations and takes results.
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // Arithmetic unit side.
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle add/subtract unit. A DIGIT-bit adder slice walks the
// operands LSB first, one digit per clock, so a WIDTH-bit result takes WIDTH/DIGIT
// cycles. Subtraction reuses the same slice by adding ~B with a carry-in of 1.
// WIDTH must be >= 2 and a multiple of DIGIT.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input logic            clk,
    input logic            rst_n,
    serial_addsub_if.slave io
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // operand A, refilled from the top with sum digits
    logic [WIDTH-1:0] b_q, b_d;       // operand B (already inverted for subtract)
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT:0]   digit_add;
    logic             carry_into_msb;
    logic             accept;
    logic             last_step;

    // One digit of the adder chain plus the handshake/step qualifiers.
    always_comb begin
        digit_add      = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                       + {{DIGIT{1'b0}}, carry_q};
        // Sum bit = a ^ b ^ carry_in, so the carry into the digit's top bit falls out directly.
        carry_into_msb = digit_add[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
        accept         = io.in_valid && (state_q == IDLE);
        last_step      = (state_q == RUN) && (cnt_q == LAST_STEP);
    end

    // Next-state logic of the IDLE -> RUN -> DONE sequence.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)        state_d = RUN;
            RUN:     if (last_step)     state_d = DONE;
            DONE:    if (io.out_ready)  state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Handshake outputs are pure decodes of the state.
    always_comb begin
        io.in_ready  = (state_q == IDLE);
        io.out_valid = (state_q == DONE);
    end

    // Datapath: capture on accept, one digit per RUN cycle, publish on the last digit.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = io.a;
            b_d     = io.b ^ {WIDTH{io.sub}};
            carry_d = io.sub;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = (a_q >> DIGIT) | (WIDTH'(digit_add[DIGIT-1:0]) << (WIDTH - DIGIT));
            b_d     = b_q >> DIGIT;
            carry_d = digit_add[DIGIT];
            cnt_d   = cnt_q + CW'(1);
            if (last_step) begin
                sum_d  = a_d;
                cout_d = digit_add[DIGIT];
                ovf_d  = carry_into_msb ^ digit_add[DIGIT];
            end
        end
    end

    // All state; reset aborts any operation in flight and clears the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values of the others.
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign io.sum  = sum_q;
    assign io.cout = cout_q;
    assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: three instances (8/1, 16/4, 8/8) driven with
// directed and random operations and compared against an integer-arithmetic model.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    serial_addsub_if #(.WIDTH(8))  if_a ();
    serial_addsub_if #(.WIDTH(16)) if_b ();
    serial_addsub_if #(.WIDTH(8))  if_c ();

    serial_addsub #(.WIDTH(8),  .DIGIT(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .io(if_a));
    serial_addsub #(.WIDTH(16), .DIGIT(4)) u_dut_b (.clk(clk), .rst_n(rst_n), .io(if_b));
    serial_addsub #(.WIDTH(8),  .DIGIT(8)) u_dut_c (.clk(clk), .rst_n(rst_n), .io(if_c));

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: unsigned and signed integer arithmetic on w-bit values.
    function automatic void ref_model(input int w, input longint unsigned a, input longint unsigned b,
                                      input bit s, output longint unsigned rs, output bit rc, output bit ro);
        longint unsigned m  = (64'd1 << w) - 64'd1;
        longint unsigned ua = a & m;
        longint unsigned ub = b & m;
        longint          half = longint'(64'd1 << (w - 1));
        longint          sa = (ua >= 64'(half)) ? longint'(ua) - 2 * half : longint'(ua);
        longint          sb = (ub >= 64'(half)) ? longint'(ub) - 2 * half : longint'(ub);
        longint          r;
        if (s) begin
            rs = (ua - ub) & m;
            rc = (ua >= ub);
            r  = sa - sb;
        end else begin
            rs = (ua + ub) & m;
            rc = ((ua + ub) > m);
            r  = sa + sb;
        end
        ro = (r > half - 1) || (r < -half);
    endfunction

    task automatic drive(input int d, input bit v, input logic [15:0] a, input logic [15:0] b,
                         input bit s, input bit r);
        case (d)
            0: begin
                if_a.in_valid = v; if_a.a = a[7:0]; if_a.b = b[7:0]; if_a.sub = s; if_a.out_ready = r;
            end
            1: begin
                if_b.in_valid = v; if_b.a = a; if_b.b = b; if_b.sub = s; if_b.out_ready = r;
            end
            default: begin
                if_c.in_valid = v; if_c.a = a[7:0]; if_c.b = b[7:0]; if_c.sub = s; if_c.out_ready = r;
            end
        endcase
    endtask

    task automatic sample(input int d, output logic rdy, output logic vld, output logic [15:0] sm,
                          output logic c, output logic o);
        case (d)
            0: begin
                rdy = if_a.in_ready; vld = if_a.out_valid; sm = {8'h00, if_a.sum}; c = if_a.cout; o = if_a.ovf;
            end
            1: begin
                rdy = if_b.in_ready; vld = if_b.out_valid; sm = if_b.sum; c = if_b.cout; o = if_b.ovf;
            end
            default: begin
                rdy = if_c.in_ready; vld = if_c.out_valid; sm = {8'h00, if_c.sum}; c = if_c.cout; o = if_c.ovf;
            end
        endcase
    endtask

    // One full transaction: accept, count latency, check result, hold under backpressure, release.
    task automatic run_op(input int d, input int w, input int steps, input logic [15:0] a,
                          input logic [15:0] b, input bit s, input int hold, input bit noise,
                          input string tag, output logic [15:0] got_s, output logic got_c,
                          output logic got_o);
        logic rdy, vld, c, o;
        logic [15:0] sm;
        longint unsigned es;
        bit ec, eo;
        int k;
        ref_model(w, 64'(a), 64'(b), s, es, ec, eo);
        @(negedge clk);
        sample(d, rdy, vld, sm, c, o);
        check({tag, ".in_ready_idle"}, 64'(rdy), 64'd1);
        drive(d, 1'b1, a, b, s, 1'b0);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
        k   = 0;
        vld = 1'b0;
        while (!vld && k < steps + 10) begin
            if (noise)
                drive(d, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                      1'($urandom_range(0, 1)), 1'b0);
            @(posedge clk);
            #1;
            k++;
            sample(d, rdy, vld, sm, c, o);
        end
        drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        check({tag, ".latency"}, 64'(k), 64'(steps));
        check({tag, ".sum"},  64'(sm), es);
        check({tag, ".cout"}, 64'(c),  64'(ec));
        check({tag, ".ovf"},  64'(o),  64'(eo));
        got_s = sm;
        got_c = c;
        got_o = o;
        for (int h = 0; h < hold; h++) begin
            if (noise) drive(d, 1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
            @(posedge clk);
            #1;
            sample(d, rdy, vld, sm, c, o);
            check({tag, ".hold_valid"}, 64'(vld), 64'd1);
            check({tag, ".hold_ready"}, 64'(rdy), 64'd0);
            check({tag, ".hold_sum"},   64'(sm),  es);
            check({tag, ".hold_flags"}, 64'({c, o}), 64'({ec, eo}));
        end
        drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        sample(d, rdy, vld, sm, c, o);
        check({tag, ".rel_ready"}, 64'(rdy), 64'd1);
        check({tag, ".rel_valid"}, 64'(vld), 64'd0);
        check({tag, ".rel_sum"},   64'(sm),  es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy, vld, c, o;
        logic [15:0] sm;
        logic [15:0] gs;
        logic gc, go;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #12;
        for (int d = 0; d < 3; d++) begin
            sample(d, rdy, vld, sm, c, o);
            check($sformatf("reset%0d.in_ready", d),  64'(rdy), 64'd1);
            check($sformatf("reset%0d.out_valid", d), 64'(vld), 64'd0);
            check($sformatf("reset%0d.result", d),    64'({sm, c, o}), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases for the 8-bit, 1-bit-per-cycle instance.
        run_op(0, 8, 8, 16'h5A, 16'h33, 1'b0, 0, 1'b0, "add_5a_33", gs, gc, go);
        check("add_5a_33.const", 64'({gs, gc, go}), 64'({16'h008D, 1'b0, 1'b1}));
        run_op(0, 8, 8, 16'hFF, 16'h01, 1'b0, 0, 1'b0, "add_ff_01", gs, gc, go);
        check("add_ff_01.const", 64'({gs, gc, go}), 64'({16'h0000, 1'b1, 1'b0}));
        run_op(0, 8, 8, 16'h7F, 16'h01, 1'b0, 0, 1'b1, "add_7f_01", gs, gc, go);
        check("add_7f_01.const", 64'({gs, gc, go}), 64'({16'h0080, 1'b0, 1'b1}));
        run_op(0, 8, 8, 16'h10, 16'h20, 1'b1, 5, 1'b0, "sub_10_20", gs, gc, go);
        check("sub_10_20.const", 64'({gs, gc, go}), 64'({16'h00F0, 1'b0, 1'b0}));
        run_op(0, 8, 8, 16'h80, 16'h01, 1'b1, 5, 1'b1, "sub_80_01", gs, gc, go);
        check("sub_80_01.const", 64'({gs, gc, go}), 64'({16'h007F, 1'b1, 1'b1}));

        // Reset asserted between edges at step 3 of a running operation.
        @(negedge clk);
        drive(0, 1'b1, 16'h55, 16'h22, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        sample(0, rdy, vld, sm, c, o);
        check("midreset.in_ready",  64'(rdy), 64'd1);
        check("midreset.out_valid", 64'(vld), 64'd0);
        check("midreset.result",    64'({sm, c, o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        sample(0, rdy, vld, sm, c, o);
        check("midreset.no_partial", 64'({rdy, vld}), 64'({1'b1, 1'b0}));
        run_op(0, 8, 8, 16'h01, 16'h01, 1'b0, 0, 1'b0, "after_reset", gs, gc, go);
        check("after_reset.const", 64'(gs), 64'h2);

        // Wider digit configurations.
        run_op(1, 16, 4, 16'hFFFF, 16'h0001, 1'b0, 2, 1'b0, "w16_ffff_1", gs, gc, go);
        check("w16_ffff_1.const", 64'({gs, gc}), 64'({16'h0000, 1'b1}));
        run_op(2, 8, 1, 16'h40, 16'h40, 1'b0, 2, 1'b1, "w8d8_40_40", gs, gc, go);
        check("w8d8_40_40.const", 64'({gs, go}), 64'({16'h0080, 1'b1}));

        // Randomized operations on all three instances.
        for (int i = 0; i < 30; i++)
            run_op(0, 8, 8, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1'(i % 2), $sformatf("rnd_a%0d", i), gs, gc, go);
        for (int i = 0; i < 15; i++)
            run_op(1, 16, 4, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1'(i % 2), $sformatf("rnd_b%0d", i), gs, gc, go);
        for (int i = 0; i < 15; i++)
            run_op(2, 8, 1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), 1'(i % 2), $sformatf("rnd_c%0d", i), gs, gc, go);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
